bcd_digit_char_sequencer: RTL and testbench

//  Downstream of the 5-digit binary-to-BCD converter in the menu display path.

---
 rtl/bcd_digit_char_sequencer_pkg.sv | 32 +++
 rtl/bcd_digit_char_sequencer_if.sv | 24 ++
 rtl/bcd_digit_char_sequencer_digit_to_char.sv | 17 +
 rtl/bcd_digit_char_sequencer.sv | 105 ++++++++++
 tb/tb_bcd_digit_char_sequencer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/bcd_digit_char_sequencer_pkg.sv
// Shared constants, FSM state type and nibble selection for the BCD digit char sequencer.
package menu_chars_pkg;

    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned NUM_DIGITS = 5;

    localparam logic [ADDR_W-1:0] CHAR_BASE_DIGIT = 7'd0;
    localparam logic [ADDR_W-1:0] CHAR_SPACE      = 7'd36;
    localparam logic [ADDR_W-1:0] CHAR_ERR        = 7'd37;

    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_FIN
    } state_e;

    // idx 0 selects the ten-thousands nibble, idx 4 the units nibble.
    function automatic logic [3:0] nibble_at(input logic [19:0] v, input logic [2:0] idx);
        logic [3:0] n;
        case (idx)
            3'd0:    n = v[19:16];
            3'd1:    n = v[15:12];
            3'd2:    n = v[11:8];
            3'd3:    n = v[7:4];
            default: n = v[3:0];
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bcd_digit_char_sequencer_if.sv
// Start/value request and char valid/ready stream of the BCD digit char sequencer.
interface bcd_digit_char_sequencer_if;
    import menu_chars_pkg::*;

    logic              start;
    logic [19:0]       bcd_value;
    logic              char_ready;
    logic              char_valid;
    logic [ADDR_W-1:0] char_addr;
    logic [2:0]        char_pos;
    logic              busy;
    logic              done;

    modport slave (
        input  start, bcd_value, char_ready,
        output char_valid, char_addr, char_pos, busy, done
    );

    modport master (
        output start, bcd_value, char_ready,
        input  char_valid, char_addr, char_pos, busy, done
    );

endinterface

// File: rtl/bcd_digit_char_sequencer_digit_to_char.sv
// Combinational BCD nibble to chars-ROM address: digits 0..9 to glyphs, anything else to error glyph.
module bcd_digit_to_char
    import menu_chars_pkg::*;
(
    input  logic [3:0]        nibble_i,
    output logic [ADDR_W-1:0] addr_o
);

    always_comb begin
        if (nibble_i > 4'd9) begin
            addr_o = CHAR_ERR;
        end else begin
            addr_o = CHAR_BASE_DIGIT + {3'b000, nibble_i};
        end
    end

endmodule

// File: rtl/bcd_digit_char_sequencer.sv
// Serialises a latched 5-digit packed BCD value into chars-ROM addresses, MSD first.
// Optional LEADING_ZERO_BLANK_EN replaces leading zeros (except units) with the blank glyph.
module bcd_digit_char_sequencer
    import menu_chars_pkg::*;
(
    input logic                   clk,
    input logic                   rst,
    bcd_digit_char_sequencer_if.slave bus
);

    state_e            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [19:0]       val_q, val_d;
    logic [3:0]        nib;
    logic [ADDR_W-1:0] digit_addr;
    logic              emit_space;
    logic              start_acc;
    logic              xfer;

    assign nib       = nibble_at(val_q, idx_q);
    assign start_acc = (state_q == ST_IDLE) && bus.start;
    assign xfer      = (state_q == ST_EMIT) && bus.char_ready;

    bcd_digit_to_char u_d2c (
        .nibble_i (nib),
        .addr_o   (digit_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        val_d   = val_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_EMIT;
                    idx_d   = '0;
                    val_d   = bus.bcd_value;
                end
            end
            ST_EMIT: begin
                if (bus.char_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic blank_q, blank_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= 1'b0;
        end else begin
            blank_q <= blank_d;
        end
    end

    // Blanking survives only while every accepted digit was zero; error nibbles count as nonzero.
    always_comb begin
        blank_d = blank_q;
        if (start_acc) begin
            blank_d = 1'b1;
        end else if (xfer && (nib != 4'd0)) begin
            blank_d = 1'b0;
        end
    end

    assign emit_space = blank_q && (nib == 4'd0) && (idx_q != LAST_IDX);
`else
    assign emit_space = 1'b0;
`endif

    always_comb begin
        bus.char_valid = (state_q == ST_EMIT);
        bus.busy       = (state_q != ST_IDLE);
        bus.done       = (state_q == ST_FIN);
        bus.char_addr  = '0;
        bus.char_pos   = '0;
        if (state_q == ST_EMIT) begin
            bus.char_addr = emit_space ? CHAR_SPACE : digit_addr;
            bus.char_pos  = idx_q;
        end
    end

endmodule

// File: tb/tb_bcd_digit_char_sequencer.sv
// Scoreboard bench for bcd_digit_char_sequencer; reference model follows the LEADING_ZERO_BLANK_EN build setting.
module tb_bcd_digit_char_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_digit_char_sequencer_if bus ();

    bcd_digit_char_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int done_exp = 0;

    bit held = 0;
    int h_addr, h_pos;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: digit i is (v / 16^(4-i)) mod 16; blanking tracks "all zero so far".
    task automatic push_expected(input int v);
        int d;
        int a;
        bit leading;
        leading = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = (v / (1 << (4 * (4 - i)))) % 16;
            if (d > 9) a = 37;
            else a = d;
`ifdef LEADING_ZERO_BLANK_EN
            if (leading && d == 0 && i < 4) a = 36;
`endif
            if (d != 0) leading = 1'b0;
            exp_q.push_back(a * 8 + i);
        end
        done_exp++;
    endtask

    // Monitor: compares every accepted character and every done pulse against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            held = 0;
        end else begin
            if (held) begin
                check("hold_valid", int'(bus.char_valid), 1);
                check("hold_addr", int'(bus.char_addr), h_addr);
                check("hold_pos", int'(bus.char_pos), h_pos);
            end
            held = bus.char_valid && !bus.char_ready;
            h_addr = int'(bus.char_addr);
            h_pos  = int'(bus.char_pos);
            if (bus.char_valid && bus.char_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_char", int'(bus.char_addr), -1);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check("char_addr", int'(bus.char_addr), e / 8);
                    check("char_pos", int'(bus.char_pos), e % 8);
                end
            end
            if (bus.done) begin
                check("done_expected", int'(done_exp > 0), 1);
                check("done_after_all_chars", exp_q.size(), 0);
                if (done_exp > 0) done_exp--;
            end
        end
    end

    task automatic run_seq(input int v, input int mode);
        int  cycles;
        int  stalls;
        bit  seen;
        @(posedge clk); #1;
        bus.bcd_value  = 20'(v);
        bus.start      = 1'b1;
        bus.char_ready = 1'b1;
        push_expected(v);
        cycles = 0;
        stalls = 0;
        seen   = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge clk); #1;
            bus.start     = ($urandom_range(0, 3) == 0);
            bus.bcd_value = 20'($urandom);
            case (mode)
                0: bus.char_ready = 1'b1;
                1: bus.char_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (bus.char_valid && bus.char_pos == 3'd2 && stalls < 3) begin
                        bus.char_ready = 1'b0;
                        stalls++;
                    end else begin
                        bus.char_ready = 1'b1;
                    end
                end
            endcase
            @(negedge clk);
            cycles++;
            if (bus.done) seen = 1;
        end
        if (!seen) begin
            check("timeout_done", 0, 1);
            exp_q.delete();
            done_exp = 0;
            rst = 1'b1;
            #2 rst = 1'b0;
        end else begin
            if (mode == 0) check("latency_to_done", cycles, 6);
            if (mode == 2) check("stall_cycles", stalls, 3);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("busy_after_done", int'(bus.busy), 0);
        check("single_done", int'(bus.done), 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    function automatic int rand_bcd();
        int v;
        int n;
        v = 0;
        for (int i = 0; i < 5; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: n = 0;
                4:          n = int'($urandom_range(10, 15));
                default:    n = int'($urandom_range(1, 9));
            endcase
            v = v * 16 + n;
        end
        return v;
    endfunction

    initial begin
        bit ok;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.char_ready = 1'b0;
        bus.bcd_value  = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", int'(bus.char_valid), 0);
        check("rst_addr", int'(bus.char_addr), 0);
        check("rst_pos", int'(bus.char_pos), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_seq(20'h01234, 0);
        run_seq(20'h00000, 0);
        run_seq(20'h0A009, 0);
        run_seq(20'h98765, 2);
        run_seq(20'h01234, 2);

        // Asynchronous reset in the middle of emission.
        @(posedge clk); #1;
        bus.bcd_value  = 20'h56789;
        bus.start      = 1'b1;
        bus.char_ready = 1'b1;
        push_expected(20'h56789);
        @(posedge clk); #1;
        bus.start = 1'b0;
        ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (bus.char_valid && bus.char_pos == 3'd2) ok = 1;
        end
        check("reach_pos2", int'(ok), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", int'(bus.char_valid), 0);
        check("async_rst_addr", int'(bus.char_addr), 0);
        check("async_rst_pos", int'(bus.char_pos), 0);
        check("async_rst_busy", int'(bus.busy), 0);
        check("async_rst_done", int'(bus.done), 0);
        exp_q.delete();
        done_exp = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(negedge clk);
        run_seq(20'h00070, 0);

        for (int k = 0; k < 30; k++) begin
            run_seq(rand_bcd(), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
